// File: rtl/tcdm_bank_responder_pkg.sv
// Shared types and constants for the TCDM bank responder.
// Provides the byte-address, data and byte-enable types seen on the tile master
// ports, plus the default bank geometry used to size the SRAM word address.
package tcdm_bank_responder_pkg;

  localparam int unsigned AddrWidth        = 32;
  localparam int unsigned DataWidth        = 32;
  localparam int unsigned BeWidth          = DataWidth / 8;
  localparam int unsigned ByteOffset       = $clog2(BeWidth);
  // Byte-address bits that reach one bank after interconnect decode.
  localparam int unsigned TCDMAddrMemWidth = 12;

  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [DataWidth-1:0] data_t;
  typedef logic [BeWidth-1:0]   be_t;

endpackage

// File: rtl/tcdm_resp_router.sv
// Fixed-latency response router.
// Tracks {valid, port index} for every granted request through a shift register
// whose depth equals the request-to-read-data latency, then decodes the oldest
// entry into a one-hot per-port response valid.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   grant_vld_i    a request was granted this cycle
//   grant_idx_i    index of the granted port
//   vld_o          one-hot (or zero) response valid per port
module tcdm_resp_router
  import tcdm_bank_responder_pkg::*;
#(
  parameter int unsigned NumPorts = 4,
  parameter int unsigned Latency  = 1,
  parameter int unsigned IdxWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                grant_vld_i,
  input  logic [IdxWidth-1:0] grant_idx_i,
  output logic [NumPorts-1:0] vld_o
);

  logic [Latency-1:0]  vld_q;
  logic [IdxWidth-1:0] idx_q [Latency];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < Latency; i++) begin
        idx_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= grant_vld_i;
      idx_q[0] <= grant_idx_i;
      for (int unsigned i = 1; i < Latency; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  always_comb begin
    vld_o = '0;
    if (vld_q[Latency-1]) begin
      vld_o[idx_q[Latency-1]] = 1'b1;
    end
  end

endmodule

// File: rtl/tcdm_bank_responder.sv
// Target-side TCDM responder for one single-ported SRAM bank.
// Round-robin arbitrates NumPorts master ports, forwards the winner to the SRAM
// (optionally through one request register) and returns a one-cycle vld pulse
// with the SRAM read data to the port that was granted, for reads and writes.
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   tcdm_slave_*_i       per-port request: valid, byte address, wen, wdata, be
//   tcdm_slave_gnt_o     combinational one-hot grant
//   tcdm_slave_vld_o     one-hot response valid
//   tcdm_slave_rdata_o   response data, broadcast to every port
//   mem_*_o, mem_rdata_i SRAM bank interface, read data one cycle after mem_req_o
module tcdm_bank_responder
  import tcdm_bank_responder_pkg::*;
#(
  parameter int unsigned NumPorts     = 4,
  parameter bit          RegisterReq  = 1'b0,
  parameter int unsigned MemAddrWidth =
      TCDMAddrMemWidth - tcdm_bank_responder_pkg::ByteOffset,
  parameter int unsigned ByteOffset   = tcdm_bank_responder_pkg::ByteOffset
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumPorts-1:0]     tcdm_slave_req_i,
  input  addr_t                   tcdm_slave_addr_i  [NumPorts],
  input  logic [NumPorts-1:0]     tcdm_slave_wen_i,
  input  data_t                   tcdm_slave_wdata_i [NumPorts],
  input  be_t                     tcdm_slave_be_i    [NumPorts],
  output logic [NumPorts-1:0]     tcdm_slave_gnt_o,
  output logic [NumPorts-1:0]     tcdm_slave_vld_o,
  output data_t                   tcdm_slave_rdata_o [NumPorts],
  output logic                    mem_req_o,
  output logic [MemAddrWidth-1:0] mem_addr_o,
  output logic                    mem_wen_o,
  output data_t                   mem_wdata_o,
  output be_t                     mem_be_o,
  input  data_t                   mem_rdata_i
);

  localparam int unsigned IdxWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int unsigned Latency  = 1 + int'(RegisterReq);

  logic                    win_vld;
  logic [IdxWidth-1:0]     win_idx;
  logic [MemAddrWidth-1:0] sel_addr;
  logic                    sel_wen;
  data_t                   sel_wdata;
  be_t                     sel_be;

  // ---------------------------------------------------------------------------
  // Round-robin arbiter
  // ---------------------------------------------------------------------------
  if (NumPorts == 1) begin : g_single
    assign win_vld = tcdm_slave_req_i[0];
    assign win_idx = '0;
  end else begin : g_rr
    logic [IdxWidth-1:0] rr_q, rr_d;
    int unsigned         cand;

    // First requester at or after the pointer, wrapping past NumPorts-1.
    always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      cand    = 0;
      for (int unsigned i = 0; i < NumPorts; i++) begin
        cand = 32'(rr_q) + i;
        if (cand >= NumPorts) begin
          cand = cand - NumPorts;
        end
        if (!win_vld && tcdm_slave_req_i[cand[IdxWidth-1:0]]) begin
          win_vld = 1'b1;
          win_idx = cand[IdxWidth-1:0];
        end
      end
    end

    always_comb begin
      rr_d = rr_q;
      if (win_vld) begin
        rr_d = (win_idx == IdxWidth'(NumPorts - 1)) ? '0 : win_idx + 1'b1;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        rr_q <= '0;
      end else begin
        rr_q <= rr_d;
      end
    end
  end

  always_comb begin
    tcdm_slave_gnt_o = '0;
    if (win_vld) begin
      tcdm_slave_gnt_o[win_idx] = 1'b1;
    end
  end

  // Winner's request fields; upper address bits were already bank-decoded.
  assign sel_addr  = tcdm_slave_addr_i[win_idx][ByteOffset +: MemAddrWidth];
  assign sel_wen   = tcdm_slave_wen_i[win_idx];
  assign sel_wdata = tcdm_slave_wdata_i[win_idx];
  assign sel_be    = tcdm_slave_be_i[win_idx];

  // ---------------------------------------------------------------------------
  // SRAM request path
  // ---------------------------------------------------------------------------
  if (RegisterReq) begin : g_req_reg
    logic                    req_q;
    logic [MemAddrWidth-1:0] addr_q;
    logic                    wen_q;
    data_t                   wdata_q;
    be_t                     be_q;

    // Refilled every cycle, so the stage never stalls the arbiter.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        req_q   <= 1'b0;
        addr_q  <= '0;
        wen_q   <= 1'b0;
        wdata_q <= '0;
        be_q    <= '0;
      end else begin
        req_q <= win_vld;
        if (win_vld) begin
          addr_q  <= sel_addr;
          wen_q   <= sel_wen;
          wdata_q <= sel_wdata;
          be_q    <= sel_be;
        end
      end
    end

    assign mem_req_o   = req_q;
    assign mem_addr_o  = addr_q;
    assign mem_wen_o   = wen_q;
    assign mem_wdata_o = wdata_q;
    assign mem_be_o    = be_q;
  end else begin : g_req_comb
    assign mem_req_o   = win_vld;
    assign mem_addr_o  = sel_addr;
    assign mem_wen_o   = sel_wen;
    assign mem_wdata_o = sel_wdata;
    assign mem_be_o    = sel_be;
  end

  // ---------------------------------------------------------------------------
  // Response path
  // ---------------------------------------------------------------------------
  tcdm_resp_router #(
    .NumPorts (NumPorts),
    .Latency  (Latency),
    .IdxWidth (IdxWidth)
  ) u_resp_router (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .grant_vld_i (win_vld),
    .grant_idx_i (win_idx),
    .vld_o       (tcdm_slave_vld_o)
  );

  always_comb begin
    for (int unsigned p = 0; p < NumPorts; p++) begin
      tcdm_slave_rdata_o[p] = mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Randomized bench for tcdm_bank_responder. Two instances (combinational and
// registered request path) share the stimulus; each owns a behavioural SRAM.
// A reference model (round-robin pointer, word-array memory, response queues)
// predicts grants, SRAM requests and responses.
module tb_tcdm_bank_responder;
  import tcdm_bank_responder_pkg::*;

  localparam int unsigned NP  = 4;
  localparam int unsigned MAW = 10;

  typedef struct {
    int    due;
    int    port;
    bit    rd;
    data_t data;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NP-1:0] req, wen;
  addr_t         addr  [NP];
  data_t         wdata [NP];
  be_t           be    [NP];

  logic [NP-1:0]  gnt_c, vld_c, gnt_r, vld_r;
  data_t          rdata_c [NP];
  data_t          rdata_r [NP];
  logic           mreq_c, mwen_c, mreq_r, mwen_r;
  logic [MAW-1:0] maddr_c, maddr_r;
  data_t          mwdata_c, mwdata_r, mrdata_c, mrdata_r;
  be_t            mbe_c, mbe_r;

  data_t sram_c [2**MAW];
  data_t sram_r [2**MAW];

  tcdm_bank_responder #(.NumPorts(NP), .RegisterReq(1'b0), .MemAddrWidth(MAW)) dut_c (
    .clk_i(clk), .rst_i(rst),
    .tcdm_slave_req_i(req), .tcdm_slave_addr_i(addr), .tcdm_slave_wen_i(wen),
    .tcdm_slave_wdata_i(wdata), .tcdm_slave_be_i(be),
    .tcdm_slave_gnt_o(gnt_c), .tcdm_slave_vld_o(vld_c), .tcdm_slave_rdata_o(rdata_c),
    .mem_req_o(mreq_c), .mem_addr_o(maddr_c), .mem_wen_o(mwen_c),
    .mem_wdata_o(mwdata_c), .mem_be_o(mbe_c), .mem_rdata_i(mrdata_c)
  );

  tcdm_bank_responder #(.NumPorts(NP), .RegisterReq(1'b1), .MemAddrWidth(MAW)) dut_r (
    .clk_i(clk), .rst_i(rst),
    .tcdm_slave_req_i(req), .tcdm_slave_addr_i(addr), .tcdm_slave_wen_i(wen),
    .tcdm_slave_wdata_i(wdata), .tcdm_slave_be_i(be),
    .tcdm_slave_gnt_o(gnt_r), .tcdm_slave_vld_o(vld_r), .tcdm_slave_rdata_o(rdata_r),
    .mem_req_o(mreq_r), .mem_addr_o(maddr_r), .mem_wen_o(mwen_r),
    .mem_wdata_o(mwdata_r), .mem_be_o(mbe_r), .mem_rdata_i(mrdata_r)
  );

  // Behavioural SRAMs: byte-masked write, 1-cycle read latency, rdata holds.
  always @(posedge clk) begin
    if (mreq_c) begin
      if (mwen_c) begin
        for (int b = 0; b < int'(BeWidth); b++)
          if (mbe_c[b]) sram_c[maddr_c][8*b +: 8] <= mwdata_c[8*b +: 8];
      end else begin
        mrdata_c <= sram_c[maddr_c];
      end
    end
  end

  always @(posedge clk) begin
    if (mreq_r) begin
      if (mwen_r) begin
        for (int b = 0; b < int'(BeWidth); b++)
          if (mbe_r[b]) sram_r[maddr_r][8*b +: 8] <= mwdata_r[8*b +: 8];
      end else begin
        mrdata_r <= sram_r[maddr_r];
      end
    end
  end

  // Reference model state.
  data_t          mem_m [2**MAW];
  bit             p_req   [NP];
  addr_t          p_addr  [NP];
  bit             p_wen   [NP];
  data_t          p_wdata [NP];
  be_t            p_be    [NP];
  int             ptr;
  int             cyc;
  int             prev_w;
  logic [MAW-1:0] prev_word;
  bit             prev_wen;
  resp_t          q_c [$];
  resp_t          q_r [$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic set_req(input int p, input bit w, input int word, input data_t d, input be_t m);
    addr_t a;
    a = $urandom();
    a[ByteOffset +: MAW] = MAW'(word);
    p_req[p]   = 1'b1;
    p_addr[p]  = a;
    p_wen[p]   = w;
    p_wdata[p] = d;
    p_be[p]    = m;
  endtask

  task automatic rand_req(input int p, input bit allow_write);
    bit w;
    w = allow_write && ($urandom_range(0, 2) == 0);
    set_req(p, w, $urandom_range(0, 15), $urandom(), be_t'($urandom_range(0, 15)));
  endtask

  task automatic drive_inputs();
    for (int p = 0; p < int'(NP); p++) begin
      req[p]   = p_req[p];
      addr[p]  = p_addr[p];
      wen[p]   = p_wen[p];
      wdata[p] = p_wdata[p];
      be[p]    = p_be[p];
    end
  endtask

  task automatic check_resp(input string tag, input bit has, input resp_t r,
                            input logic [NP-1:0] vld, input data_t rd);
    logic [NP-1:0] ev;
    ev = '0;
    if (has) ev[r.port] = 1'b1;
    check_eq({tag, "_vld"}, 32'(vld), 32'(ev));
    if (has && r.rd) check_eq({tag, "_rdata"}, rd, r.data);
  endtask

  task automatic run_cycle();
    int             w;
    logic [NP-1:0]  eg;
    logic [MAW-1:0] word;
    resp_t          r, rn;
    @(posedge clk); #1;
    drive_inputs();
    #4;
    w = -1;
    for (int i = 0; i < int'(NP); i++)
      if (w < 0 && p_req[(ptr + i) % NP]) w = (ptr + i) % NP;
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    word = '0;
    if (w >= 0) word = p_addr[w][ByteOffset +: MAW];

    check_eq("gnt_comb", 32'(gnt_c), 32'(eg));
    check_eq("gnt_reg", 32'(gnt_r), 32'(eg));
    check_eq("mem_req_comb", 32'(mreq_c), 32'(w >= 0));
    if (w >= 0) begin
      check_eq("mem_addr_comb", 32'(maddr_c), 32'(word));
      check_eq("mem_wen_comb", 32'(mwen_c), 32'(p_wen[w]));
      if (p_wen[w]) begin
        check_eq("mem_wdata_comb", mwdata_c, p_wdata[w]);
        check_eq("mem_be_comb", 32'(mbe_c), 32'(p_be[w]));
      end
    end
    check_eq("mem_req_reg", 32'(mreq_r), 32'(prev_w >= 0));
    if (prev_w >= 0) begin
      check_eq("mem_addr_reg", 32'(maddr_r), 32'(prev_word));
      check_eq("mem_wen_reg", 32'(mwen_r), 32'(prev_wen));
    end

    if (q_c.size() > 0 && q_c[0].due == cyc) begin
      r = q_c.pop_front();
      check_resp("resp_comb", 1'b1, r, vld_c, rdata_c[r.port]);
    end else begin
      check_resp("resp_comb", 1'b0, r, vld_c, rdata_c[0]);
    end
    if (q_r.size() > 0 && q_r[0].due == cyc) begin
      r = q_r.pop_front();
      check_resp("resp_reg", 1'b1, r, vld_r, rdata_r[r.port]);
    end else begin
      check_resp("resp_reg", 1'b0, r, vld_r, rdata_r[0]);
    end

    // Accesses take effect in grant order; a read sees every earlier write.
    if (w >= 0) begin
      rn.port = w;
      rn.rd   = !p_wen[w];
      rn.data = '0;
      if (rn.rd) begin
        rn.data = mem_m[word];
      end else begin
        for (int b = 0; b < int'(BeWidth); b++)
          if (p_be[w][b]) mem_m[word][8*b +: 8] = p_wdata[w][8*b +: 8];
      end
      rn.due = cyc + 1;
      q_c.push_back(rn);
      rn.due = cyc + 2;
      q_r.push_back(rn);
      ptr = (w + 1) % NP;
      p_req[w] = 1'b0;
      prev_wen = p_wen[w];
    end
    prev_w    = w;
    prev_word = word;
    cyc++;
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int p = 0; p < int'(NP); p++) p_req[p] = 1'b0;
    drive_inputs();
    for (int k = 0; k < cycles; k++) begin
      #4;
      check_eq("rst_vld_comb", 32'(vld_c), 32'h0);
      check_eq("rst_vld_reg", 32'(vld_r), 32'h0);
      check_eq("rst_mem_req_reg", 32'(mreq_r), 32'h0);
      check_eq("rst_gnt", 32'(gnt_c), 32'h0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    q_c.delete();
    q_r.delete();
    ptr    = 0;
    prev_w = -1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) run_cycle();
  endtask

  initial begin
    ptr = 0; cyc = 0; prev_w = -1; prev_word = '0; prev_wen = 1'b0;
    for (int p = 0; p < int'(NP); p++) begin
      p_req[p] = 1'b0; p_addr[p] = '0; p_wen[p] = 1'b0; p_wdata[p] = '0; p_be[p] = '0;
    end
    drive_inputs();
    for (int i = 0; i < 2**MAW; i++) begin
      mem_m[i] = $urandom();
      if (i == 4) mem_m[i] = 32'hDEAD_BEEF;
      if (i == 2) mem_m[i] = 32'hAAAA_AAAA;
      sram_c[i] <= mem_m[i];
      sram_r[i] <= mem_m[i];
    end
    do_reset(2);

    // Single read, port 2, byte address 0x10 -> word 4.
    set_req(2, 1'b0, 4, '0, '0);
    p_addr[2] = 32'h0000_0010;
    idle(3);

    // Partial write on port 0 followed by a read of the same word on port 1.
    set_req(0, 1'b1, 2, 32'h1234_5678, 4'b0011);
    p_addr[0] = 32'h0000_0008;
    set_req(1, 1'b0, 2, '0, '0);
    p_addr[1] = 32'h0000_0008;
    idle(4);

    // All ports requesting continuously from reset.
    do_reset(1);
    for (int k = 0; k < 8; k++) begin
      for (int p = 0; p < int'(NP); p++) if (!p_req[p]) rand_req(p, 1'b0);
      run_cycle();
    end
    for (int p = 0; p < int'(NP); p++) p_req[p] = 1'b0;
    idle(3);

    // Move pointer to 2, then ports 1 and 3 compete.
    do_reset(1);
    rand_req(0, 1'b0);
    rand_req(1, 1'b0);
    idle(2);
    rand_req(1, 1'b0);
    rand_req(3, 1'b0);
    idle(4);

    // Reset the cycle after a grant: the response must never appear.
    set_req(0, 1'b0, 7, '0, '0);
    run_cycle();
    do_reset(2);
    idle(4);

    // Zero byte-enable write is still issued and acknowledged.
    set_req(2, 1'b1, 5, $urandom(), 4'b0000);
    idle(1);
    set_req(2, 1'b0, 5, '0, '0);
    idle(4);

    // Randomized traffic with held requests.
    for (int k = 0; k < 600; k++) begin
      for (int p = 0; p < int'(NP); p++)
        if (!p_req[p] && ($urandom_range(0, 1) == 1)) rand_req(p, 1'b1);
      run_cycle();
    end
    for (int p = 0; p < int'(NP); p++) p_req[p] = 1'b0;
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
